// File: rtl/bkg_port_scheduler.sv
// Background pixel RAM port scheduler: the display path has priority, and a
// host req/ack port uses the idle slots. Also maps screen coordinates to RAM addresses with vertical scroll.
module bkg_port_scheduler #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 160,
  parameter int SHIFT_X = 2,
  parameter int SHIFT_Y = 2,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 24
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic [7:0]        scroll_in,
  input  logic              scroll_load,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] bkg_rgb,
  output logic              bkg_valid,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [DATA_W-1:0] ram_data_In,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_data_Out
);

  localparam logic [10:0] LIM_X = 11'(IMG_W << SHIFT_X);
  localparam logic [10:0] LIM_Y = 11'(IMG_H << SHIFT_Y);

  typedef enum logic [1:0] {H_IDLE, H_ISSUE, H_WAIT, H_RESP} hstate_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} tag_t;

  hstate_t           r_hstate;
  hstate_t           w_hstate_nxt;
  tag_t              r_tag1;
  tag_t              r_tag2;
  logic              r_host_we;
  logic [7:0]        r_scroll_active;
  logic [7:0]        r_scroll_pend;
  logic              w_disp_slot;
  logic              w_host_grant;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_row_raw;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_disp_addr;

  assign w_disp_slot = pix_en & ({1'b0, DrawX} < LIM_X) & ({1'b0, DrawY} < LIM_Y);

  // The scrolled row can exceed the image by less than one image height, so a single subtraction wraps it.
  assign w_col       = ADDR_W'(DrawX >> SHIFT_X);
  assign w_row_raw   = ADDR_W'(DrawY >> SHIFT_Y) + ADDR_W'(r_scroll_active);
  assign w_row       = (w_row_raw >= ADDR_W'(IMG_H)) ? (w_row_raw - ADDR_W'(IMG_H)) : w_row_raw;
  assign w_disp_addr = (w_row * ADDR_W'(IMG_W)) + w_col;

  // Host FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hstate <= H_IDLE;
    end else begin
      r_hstate <= w_hstate_nxt;
    end
  end

  // Host FSM next state and grant; the host only gets slots the display leaves free.
  always_comb begin
    w_hstate_nxt = r_hstate;
    w_host_grant = 1'b0;
    case (r_hstate)
      H_IDLE: begin
        if (host_req && !w_disp_slot) begin
          w_host_grant = 1'b1;
          w_hstate_nxt = H_ISSUE;
        end else begin
          w_hstate_nxt = H_IDLE;
        end
      end
      H_ISSUE: w_hstate_nxt = H_WAIT;
      H_WAIT:  w_hstate_nxt = H_RESP;
      H_RESP:  w_hstate_nxt = H_IDLE;
      default: w_hstate_nxt = H_IDLE;
    endcase
  end

  // Scroll registers: a same-cycle load only reaches pend, so the active value switches one frame later.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_scroll_active <= 8'd0;
      r_scroll_pend   <= 8'd0;
    end else begin
      if (frame_start) begin
        r_scroll_active <= r_scroll_pend;
      end
      if (scroll_load && (scroll_in < 8'(IMG_H))) begin
        r_scroll_pend <= scroll_in;
      end
    end
  end

  // RAM issue stage, tag pipeline and response registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ram_read_address  <= '0;
      ram_write_address <= '0;
      ram_data_In       <= '0;
      ram_we            <= 1'b0;
      r_tag1            <= TAG_NONE;
      r_tag2            <= TAG_NONE;
      r_host_we         <= 1'b0;
      bkg_valid         <= 1'b0;
      bkg_rgb           <= '0;
      host_ack          <= 1'b0;
      host_rdata        <= '0;
    end else begin
      ram_we <= w_host_grant & host_we;
      if (w_disp_slot) begin
        ram_read_address <= w_disp_addr;
      end else if (w_host_grant) begin
        ram_read_address <= host_addr;
      end
      if (w_host_grant && host_we) begin
        ram_write_address <= host_addr;
        ram_data_In       <= host_wdata;
      end
      if (w_host_grant) begin
        r_host_we <= host_we;
      end
      r_tag1    <= w_disp_slot ? TAG_DISP : (w_host_grant ? TAG_HOST : TAG_NONE);
      r_tag2    <= r_tag1;
      bkg_valid <= (r_tag2 == TAG_DISP);
      host_ack  <= (r_tag2 == TAG_HOST);
      if (r_tag2 == TAG_DISP) begin
        bkg_rgb <= ram_data_Out;
      end
      if ((r_tag2 == TAG_HOST) && !r_host_we) begin
        host_rdata <= ram_data_Out;
      end
    end
  end

endmodule

// File: tb/tb_bkg_port_scheduler.sv
// Self-checking bench: RAM model, cycle-scheduled reference model with a per-cycle monitor,
// table of address vectors, hand-written host/reset sequences and a randomized phase.
module tb_bkg_port_scheduler;

  localparam int NMEM = 25600;

  logic        Clk = 1'b0;
  logic        Reset, pix_en, frame_start, scroll_load, host_req, host_we;
  logic [9:0]  DrawX, DrawY;
  logic [7:0]  scroll_in;
  logic [14:0] host_addr, ram_read_address, ram_write_address;
  logic [23:0] host_wdata, host_rdata, bkg_rgb, ram_data_In, ram_data_Out;
  logic        host_ack, bkg_valid, ram_we;

  logic [23:0] mem [0:NMEM-1];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;
  int mon_s;

  // expectations scheduled by cycle, ring of 8
  bit          e_bv [8];
  logic [23:0] e_rgb [8];
  bit          e_ack [8];
  bit          e_rd [8];
  logic [23:0] e_rdata [8];
  bit          e_we [8];
  logic [14:0] e_waddr [8];
  logic [23:0] e_wdata [8];

  int m_active, m_pend, m_hfree, m_grant_cyc;
  bit m_granted;

  bkg_port_scheduler dut (
    .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .scroll_in(scroll_in), .scroll_load(scroll_load),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .bkg_rgb(bkg_rgb), .bkg_valid(bkg_valid),
    .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
    .ram_data_In(ram_data_In), .ram_we(ram_we), .ram_data_Out(ram_data_Out)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // single-port RAM with registered read
  always @(posedge Clk) begin
    if (ram_we) mem[ram_write_address] <= ram_data_In;
    ram_data_Out <= mem[ram_read_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr(input int s);
    e_bv[s] = 1'b0; e_rgb[s] = 24'd0; e_ack[s] = 1'b0; e_rd[s] = 1'b0;
    e_rdata[s] = 24'd0; e_we[s] = 1'b0; e_waddr[s] = 15'd0; e_wdata[s] = 24'd0;
  endtask

  // per-cycle comparison against the scheduled expectations
  always @(negedge Clk) begin
    if (mon_en) begin
      mon_s = cyc & 7;
      chk("bkg_valid", 32'(bkg_valid), 32'(e_bv[mon_s]));
      if (e_bv[mon_s]) chk("bkg_rgb", 32'(bkg_rgb), 32'(e_rgb[mon_s]));
      chk("host_ack", 32'(host_ack), 32'(e_ack[mon_s]));
      if (e_ack[mon_s] && e_rd[mon_s]) chk("host_rdata", 32'(host_rdata), 32'(e_rdata[mon_s]));
      chk("ram_we", 32'(ram_we), 32'(e_we[mon_s]));
      if (e_we[mon_s]) begin
        chk("ram_waddr", 32'(ram_write_address), 32'(e_waddr[mon_s]));
        chk("ram_wdata", 32'(ram_data_In), 32'(e_wdata[mon_s]));
      end
      clr(mon_s);
    end
  end

  // Apply one cycle of inputs, predict its outcome from the behavioural rules, advance one clock.
  task automatic drive(input bit rst, input bit pe, input int x, input int y, input bit fs,
                       input bit sl, input int si, input bit hr, input bit hw, input int ha, input int hd);
    int k, cap_a;
    bit cap_d, cap_h;
    Reset = rst; pix_en = pe; DrawX = x[9:0]; DrawY = y[9:0]; frame_start = fs;
    scroll_load = sl; scroll_in = si[7:0]; host_req = hr; host_we = hw;
    host_addr = ha[14:0]; host_wdata = hd[23:0];
    k = cyc; cap_d = 1'b0; cap_h = 1'b0; cap_a = 0; m_granted = 1'b0;
    if (rst) begin
      for (int i = 1; i <= 3; i++) clr((k + i) & 7);
      m_active = 0; m_pend = 0; m_hfree = k + 1;
    end else begin
      if (pe && x < 640 && y < 640) begin
        cap_a = ((y / 4 + m_active) % 160) * 160 + x / 4;
        e_bv[(k + 3) & 7] = 1'b1;
        cap_d = 1'b1;
      end else if (hr && k >= m_hfree) begin
        m_granted = 1'b1; m_grant_cyc = k; m_hfree = k + 4;
        e_ack[(k + 3) & 7] = 1'b1;
        e_rd[(k + 3) & 7] = !hw;
        if (hw) begin
          e_we[(k + 1) & 7] = 1'b1;
          e_waddr[(k + 1) & 7] = ha[14:0];
          e_wdata[(k + 1) & 7] = hd[23:0];
        end else begin
          cap_h = 1'b1; cap_a = ha;
        end
      end
      if (fs) m_active = m_pend;
      if (sl && si < 160) m_pend = si;
    end
    @(posedge Clk); #1;
    if (cap_d) e_rgb[(k + 3) & 7] = mem[cap_a];
    if (cap_h) e_rdata[(k + 3) & 7] = mem[cap_a];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int x, input int y, input bit fs, input bit sl, input int si);
    drive(0, 1, x, y, fs, sl, si, 0, 0, 0, 0);
    idle(1);
  endtask

  // Host transaction from an idle FSM; pix strobe (optionally off-image) only in the first cycle.
  task automatic host_txn(input bit pe, input int x, input bit hw, input int ha, input int hd,
                          output int acks, output int lat, output logic [23:0] rdata,
                          output logic [14:0] first_raddr);
    int t0;
    acks = 0; lat = -1; rdata = 24'd0; t0 = cyc; first_raddr = 15'd0;
    for (int i = 0; i < 8; i++) begin
      drive(0, pe && (i == 0), x, 10, 0, 0, 0, acks == 0, hw, ha, hd);
      if (i == 0) first_raddr = ram_read_address;
      if (host_ack) begin
        acks++;
        if (acks == 1) begin lat = cyc - t0; rdata = host_rdata; end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bkg_rgb"}, 32'(bkg_rgb), 32'd0);
    chk({tag, "_bkg_valid"}, 32'(bkg_valid), 32'd0);
    chk({tag, "_host_ack"}, 32'(host_ack), 32'd0);
    chk({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
    chk({tag, "_raddr"}, 32'(ram_read_address), 32'd0);
    chk({tag, "_waddr"}, 32'(ram_write_address), 32'd0);
    chk({tag, "_wdata"}, 32'(ram_data_In), 32'd0);
    chk({tag, "_we"}, 32'(ram_we), 32'd0);
  endtask

  typedef struct { int x; int y; int s; int addr; } vec_t;
  vec_t tbl [8];

  int acks, lat, nwe, nvalid, t0, we_c;
  logic [23:0] rd;
  logic [14:0] fra;
  bit pprev, rq, rw, pe_r;
  int ra, rdat, gat;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NMEM; i++) mem[i] = 24'($urandom);
    for (int i = 0; i < 8; i++) clr(i);
    m_active = 0; m_pend = 0; m_hfree = 0; m_grant_cyc = 0; m_granted = 1'b0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    chk_all_zero("reset");

    tbl[0] = '{x: 8,   y: 4,   s: 0,   addr: 162};
    tbl[1] = '{x: 0,   y: 40,  s: 150, addr: 0};
    tbl[2] = '{x: 639, y: 639, s: 0,   addr: 25599};
    tbl[3] = '{x: 639, y: 639, s: 159, addr: 25439};
    tbl[4] = '{x: 100, y: 200, s: 10,  addr: 9625};
    tbl[5] = '{x: 4,   y: 0,   s: 159, addr: 25441};
    tbl[6] = '{x: 640, y: 0,   s: 0,   addr: 25441};
    tbl[7] = '{x: 0,   y: 640, s: 0,   addr: 25441};
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 1, tbl[i].s, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 1, tbl[i].x, tbl[i].y, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("tbl%0d_addr", i), 32'(ram_read_address), 32'(tbl[i].addr));
      idle(3);
    end

    // out-of-range scroll load is ignored
    drive(0, 0, 0, 0, 0, 1, 150, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 200, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 40, 0, 0, 0, 0, 0, 0, 0);
    chk("scroll_ignore_200", 32'(ram_read_address), 32'd0);
    idle(1);
    // same-cycle load and frame_start: new value only becomes active at the next frame
    drive(0, 0, 0, 0, 1, 1, 10, 0, 0, 0, 0);
    drive(0, 1, 0, 40, 0, 0, 0, 0, 0, 0, 0);
    chk("scroll_same_cycle", 32'(ram_read_address), 32'd0);
    idle(1);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 40, 0, 0, 0, 0, 0, 0, 0);
    chk("scroll_next_frame", 32'(ram_read_address), 32'd3200);
    idle(4);

    host_txn(0, 0, 0, 32'h1234, 0, acks, lat, rd, fra);
    chk("hrd_acks", 32'(acks), 32'd1);
    chk("hrd_lat", 32'(lat), 32'd3);
    chk("hrd_data", 32'(rd), 32'(mem[15'h1234]));

    // host write while pix_en toggles
    nwe = 0; nvalid = 0; acks = 0; we_c = -1; t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      drive(0, (i % 2 == 0) && (i < 12), 4 * i, 8, 0, 0, 0, acks == 0, 1, 5, 32'hABCDEF);
      if (ram_we) begin nwe++; we_c = cyc - t0; end
      if (bkg_valid) nvalid++;
      if (host_ack) acks++;
    end
    chk("hwr_we_cycles", 32'(nwe), 32'd1);
    chk("hwr_we_when", 32'(we_c), 32'd2);
    chk("hwr_valids", 32'(nvalid), 32'd6);
    chk("hwr_acks", 32'(acks), 32'd1);
    host_txn(0, 0, 0, 5, 0, acks, lat, rd, fra);
    chk("hwr_readback", 32'(rd), 32'hABCDEF);

    // off-image pix strobe: host wins that same cycle
    host_txn(1, 700, 0, 32'h0777, 0, acks, lat, rd, fra);
    chk("offimg_raddr", 32'(fra), 32'h0777);
    chk("offimg_lat", 32'(lat), 32'd3);
    chk("offimg_data", 32'(rd), 32'(mem[15'h0777]));

    // reset while FSM is in H_WAIT
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 100, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 100, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 100, 0);
    chk_all_zero("rst_wait");
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (host_ack) acks++;
    end
    chk("rst_wait_noack", 32'(acks), 32'd0);
    host_txn(0, 0, 0, 200, 0, acks, lat, rd, fra);
    chk("post_rst_acks", 32'(acks), 32'd1);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", 32'(rd), 32'(mem[200]));

    // randomized traffic against the reference model
    pprev = 1'b0; rq = 1'b0; rw = 1'b0; ra = 0; rdat = 0; gat = -1;
    for (int i = 0; i < 2000; i++) begin
      if (rq && gat >= 0 && cyc == gat + 3) rq = 1'b0;
      if (!rq && $urandom_range(0, 2) == 0) begin
        rq = 1'b1; rw = 1'($urandom_range(0, 1)); ra = int'($urandom_range(0, NMEM - 1));
        rdat = int'($urandom & 32'h00FFFFFF); gat = -1;
      end
      pe_r = !pprev && ($urandom_range(0, 1) == 1);
      drive(0, pe_r, int'($urandom_range(0, 719)), int'($urandom_range(0, 699)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 255)),
            rq, rw, ra, rdat);
      pprev = pe_r;
      if (m_granted) gat = m_grant_cyc;
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
